// File: rtl/seq_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_playback_ctrl
// Description : Sequence selection from pushbuttons, tag-RAM lookup and
//               tempo-paced pattern-ROM stepping with loop/stop at end marker.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_playback_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int SEQ_W    = 6,
    parameter int TICK_DIV = 2500000
) (
    input  logic              CLK_50,
    input  logic              reset,
    input  logic              pb_seq_up,
    input  logic              pb_seq_dn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [SEQ_W:0]    tag_addr,
    input  logic [31:0]       tag_q,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_q,
    output logic [SEQ_W-1:0]  seq_num,
    output logic [9:0]        led_data,
    output logic              busy,
    output logic              step_pulse,
    output logic              done,
    output logic              tag_err
);

    localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TAG_RD    = 3'd1,
        S_TAG_W1    = 3'd2,
        S_TAG_W2    = 3'd3,
        S_TAG_CHK   = 3'd4,
        S_WAIT_TICK = 3'd5,
        S_ROM_W     = 3'd6,
        S_ROM_CHK   = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_CNT_W-1:0]  r_tick_cnt;
    logic                w_tick;
    logic                r_up_hist;
    logic                r_dn_hist;
    logic                w_up_edge;
    logic                w_dn_edge;
    logic                w_press_up;
    logic                w_press_dn;
    logic                w_press;
    logic [SEQ_W-1:0]    r_seq_num;
    logic [SEQ_W:0]      r_tag_addr;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [ADDR_W-1:0]   r_start_addr;
    logic [9:0]          r_led_data;
    logic                w_tag_load;
    logic                w_rom_load_tag;
    logic                w_rom_load_start;
    logic                w_rom_inc;
    logic                w_step;
    logic                w_done;
    logic                w_tag_err;
    logic                w_unused;

    assign w_unused = ^{tag_q[30:ADDR_W], rom_q[5:2]};

    assign w_tick     = (r_tick_cnt == c_TICK_LAST);
    assign w_up_edge  = r_up_hist & ~pb_seq_up;
    assign w_dn_edge  = r_dn_hist & ~pb_seq_dn;
    // Edges on both buttons in the same cycle cancel out.
    assign w_press_up = w_up_edge & ~w_dn_edge;
    assign w_press_dn = w_dn_edge & ~w_up_edge;
    assign w_press    = w_press_up | w_press_dn;

    always_comb begin
        w_next_state     = r_state;
        w_tag_load       = 1'b0;
        w_rom_load_tag   = 1'b0;
        w_rom_load_start = 1'b0;
        w_rom_inc        = 1'b0;
        w_step           = 1'b0;
        w_done           = 1'b0;
        w_tag_err        = 1'b0;
        if (r_state != S_IDLE && stop) begin
            w_next_state = S_IDLE;
        end else if (r_state != S_IDLE && w_press) begin
            w_next_state = S_TAG_RD;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !w_press) w_next_state = S_TAG_RD;
                end
                S_TAG_RD: begin
                    w_tag_load   = 1'b1;
                    w_next_state = S_TAG_W1;
                end
                S_TAG_W1:  w_next_state = S_TAG_W2;
                S_TAG_W2:  w_next_state = S_TAG_CHK;
                S_TAG_CHK: begin
                    if (!tag_q[31]) begin
                        w_tag_err    = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_rom_load_tag = 1'b1;
                        w_next_state   = S_WAIT_TICK;
                    end
                end
                S_WAIT_TICK: begin
                    if (w_tick) w_next_state = S_ROM_W;
                end
                S_ROM_W:   w_next_state = S_ROM_CHK;
                S_ROM_CHK: begin
                    w_step = 1'b1;
                    if (rom_q[1:0] == 2'b11) begin
                        if (loop_en) begin
                            w_rom_load_start = 1'b1;
                            w_next_state     = S_WAIT_TICK;
                        end else begin
                            w_done       = 1'b1;
                            w_next_state = S_IDLE;
                        end
                    end else begin
                        w_rom_inc    = 1'b1;
                        w_next_state = S_WAIT_TICK;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_up_hist    <= 1'b1;
            r_dn_hist    <= 1'b1;
            r_seq_num    <= '0;
            r_tag_addr   <= '0;
            r_rom_addr   <= '0;
            r_start_addr <= '0;
            r_led_data   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_CNT_W'(1);
            r_up_hist  <= pb_seq_up;
            r_dn_hist  <= pb_seq_dn;
            if (w_press_up) begin
                r_seq_num <= r_seq_num + SEQ_W'(1);
            end else if (w_press_dn) begin
                r_seq_num <= r_seq_num - SEQ_W'(1);
            end
            if (w_tag_load) r_tag_addr <= {1'b0, r_seq_num};
            if (w_rom_load_tag) begin
                r_start_addr <= tag_q[ADDR_W-1:0];
                r_rom_addr   <= tag_q[ADDR_W-1:0];
            end else if (w_rom_load_start) begin
                r_rom_addr <= r_start_addr;
            end else if (w_rom_inc) begin
                r_rom_addr <= r_rom_addr + ADDR_W'(1);
            end
            if (w_step) r_led_data <= rom_q[15:6];
        end
    end

    assign tag_addr   = r_tag_addr;
    assign rom_addr   = r_rom_addr;
    assign seq_num    = r_seq_num;
    assign led_data   = r_led_data;
    assign busy       = (r_state != S_IDLE);
    assign step_pulse = w_step;
    assign done       = w_done;
    assign tag_err    = w_tag_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_playback_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seq_playback_ctrl
// Description : Self-checking bench for seq_playback_ctrl with RAM/ROM models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_playback_ctrl;

    localparam int ADDR_W   = 10;
    localparam int SEQ_W    = 6;
    localparam int TICK_DIV = 4;

    logic              CLK_50    = 1'b0;
    logic              reset     = 1'b1;
    logic              pb_seq_up = 1'b1;
    logic              pb_seq_dn = 1'b1;
    logic              start     = 1'b0;
    logic              stop      = 1'b0;
    logic              loop_en   = 1'b0;
    logic [SEQ_W:0]    tag_addr;
    logic [31:0]       tag_q;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_q;
    logic [SEQ_W-1:0]  seq_num;
    logic [9:0]        led_data;
    logic              busy;
    logic              step_pulse;
    logic              done;
    logic              tag_err;

    logic [31:0] tag_mem [0:127];
    logic [15:0] rom_mem [0:1023];
    logic [31:0] tag_d1;
    logic [15:0] rom_d1;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int seq_m = 0;

    seq_playback_ctrl #(
        .ADDR_W   (ADDR_W),
        .SEQ_W    (SEQ_W),
        .TICK_DIV (TICK_DIV)
    ) u_dut (
        .CLK_50     (CLK_50),
        .reset      (reset),
        .pb_seq_up  (pb_seq_up),
        .pb_seq_dn  (pb_seq_dn),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .tag_addr   (tag_addr),
        .tag_q      (tag_q),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .seq_num    (seq_num),
        .led_data   (led_data),
        .busy       (busy),
        .step_pulse (step_pulse),
        .done       (done),
        .tag_err    (tag_err)
    );

    always #10 CLK_50 = ~CLK_50;

    // Two-cycle read latency memories; cyc counts clocks since reset (tempo phase).
    always @(posedge CLK_50) begin
        tag_d1 <= tag_mem[tag_addr];
        tag_q  <= tag_d1;
        rom_d1 <= rom_mem[rom_addr];
        rom_q  <= rom_d1;
        cyc    <= reset ? 0 : cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input bit up, input bit dn, input int hold);
        pb_seq_up = ~up;
        pb_seq_dn = ~dn;
        repeat (hold) @(negedge CLK_50);
        pb_seq_up = 1'b1;
        pb_seq_dn = 1'b1;
        @(negedge CLK_50);
        if (up ^ dn) seq_m = up ? (seq_m + 1) % 64 : (seq_m + 63) % 64;
        chk("seq_num", 32'(seq_num), 32'(seq_m));
    endtask

    task automatic goto_seq(input int sn);
        int d;
        d = (sn - seq_m + 64) % 64;
        if (d <= 32) repeat (d) press(1'b1, 1'b0, 1);
        else         repeat (64 - d) press(1'b0, 1'b1, 1);
    endtask

    task automatic wait_step(input string tag);
        int k;
        k = 0;
        while (!step_pulse && k < 40) begin
            @(negedge CLK_50);
            k++;
        end
        chk(tag, 32'(step_pulse), 32'd1);
    endtask

    // Reference: walk the ROM from the tag's start address, following marker/loop rules.
    task automatic run_playback(input int sn, input bit lp, input int steps);
        logic [ADDR_W-1:0] exp_addr[$];
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] start_a;
        logic [ADDR_W-1:0] rom_before;
        logic [ADDR_W-1:0] nxt_a;
        logic [9:0]        exp_led;
        bit                valid;
        bit                finished;
        bit                last;
        int                idx;
        goto_seq(sn);
        valid   = tag_mem[sn][31];
        start_a = tag_mem[sn][ADDR_W-1:0];
        a       = start_a;
        for (int i = 0; i < 1100 && exp_addr.size() < steps; i++) begin
            exp_addr.push_back(a);
            if (rom_mem[a][1:0] == 2'b11) begin
                if (!lp) break;
                a = start_a;
            end else begin
                a = a + 1'b1;
            end
        end
        loop_en    = lp;
        rom_before = rom_addr;
        start      = 1'b1;
        @(negedge CLK_50);
        start = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
        @(negedge CLK_50);
        chk("tag_addr", 32'(tag_addr), 32'(sn));
        if (!valid) begin
            @(negedge CLK_50);
            @(negedge CLK_50);
            chk("tag_err", 32'(tag_err), 32'd1);
            @(negedge CLK_50);
            chk("busy_after_err", 32'(busy), 32'd0);
            chk("rom_addr_hold", 32'(rom_addr), 32'(rom_before));
            return;
        end
        idx      = 0;
        finished = 1'b0;
        for (int k = 0; k < 20 + 8 * exp_addr.size() && !finished; k++) begin
            if (tag_err) chk("tag_err_spurious", 32'(tag_err), 32'd0);
            if (step_pulse) begin
                chk("rom_addr", 32'(rom_addr), 32'(exp_addr[idx]));
                chk("step_phase", 32'(cyc % TICK_DIV), 32'd1);
                last = (rom_mem[exp_addr[idx]][1:0] == 2'b11) && !lp;
                chk("done", 32'(done), 32'(last));
                exp_led = rom_mem[exp_addr[idx]][15:6];
                nxt_a   = (rom_mem[exp_addr[idx]][1:0] == 2'b11) ? start_a : exp_addr[idx] + 1'b1;
                idx++;
                @(negedge CLK_50);
                chk("led_data", 32'(led_data), 32'(exp_led));
                if (last) begin
                    chk("busy_end", 32'(busy), 32'd0);
                    finished = 1'b1;
                end else if (idx == exp_addr.size()) begin
                    stop = 1'b1;
                    @(negedge CLK_50);
                    stop = 1'b0;
                    chk("busy_stop", 32'(busy), 32'd0);
                    chk("rom_hold_stop", 32'(rom_addr), 32'(nxt_a));
                    chk("led_hold_stop", 32'(led_data), 32'(exp_led));
                    finished = 1'b1;
                end
            end else begin
                if (done) chk("done_spurious", 32'(done), 32'd0);
                @(negedge CLK_50);
            end
        end
        chk("playback_finished", 32'(finished), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [1:0]  lo;
        int          base;
        int          len;
        int          sn;
        int          kind;
        bit          lp;

        for (int i = 0; i < 128; i++) begin
            w = $urandom;
            tag_mem[i] = {1'b0, w[30:0]};
        end
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            rom_mem[i] = {w[15:2], 2'b11};
        end
        tag_mem[5] = 32'h8000_0010;
        rom_mem[16'h10] = 16'hFFC0;
        rom_mem[16'h11] = 16'h0000;
        rom_mem[16'h12] = 16'h0043;
        tag_mem[6] = 32'h8000_0030;
        rom_mem[16'h30] = 16'h1540;
        rom_mem[16'h31] = 16'h2AC3;
        tag_mem[7] = 32'h0000_0020;
        tag_mem[9] = 32'h8000_03FF;
        rom_mem[16'h3FF] = 16'h0000;
        rom_mem[16'h000] = 16'h0003;

        reset = 1'b1;
        repeat (3) @(negedge CLK_50);
        chk("rst_seq_num",  32'(seq_num),    32'd0);
        chk("rst_tag_addr", 32'(tag_addr),   32'd0);
        chk("rst_rom_addr", 32'(rom_addr),   32'd0);
        chk("rst_led_data", 32'(led_data),   32'd0);
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_step",     32'(step_pulse), 32'd0);
        chk("rst_done",     32'(done),       32'd0);
        chk("rst_tag_err",  32'(tag_err),    32'd0);
        reset = 1'b0;
        @(negedge CLK_50);

        repeat (3) press(1'b1, 1'b0, 1);
        repeat (3) press(1'b0, 1'b1, 1);
        repeat (4) press(1'b0, 1'b1, 1);
        press(1'b1, 1'b1, 2);
        press(1'b1, 1'b0, 3);
        press(1'b0, 1'b1, 4);
        for (int i = 0; i < 20; i++) begin
            kind = $urandom_range(0, 2);
            press(kind != 1, kind != 0, $urandom_range(1, 3));
        end

        run_playback(5, 1'b0, 2000);
        run_playback(5, 1'b1, 7);
        run_playback(7, 1'b0, 2000);
        run_playback(9, 1'b0, 2000);

        // Button press mid-playback restarts on the new sequence.
        goto_seq(5);
        loop_en = 1'b1;
        start   = 1'b1;
        @(negedge CLK_50);
        start = 1'b0;
        wait_step("mid_first_step");
        @(negedge CLK_50);
        pb_seq_up = 1'b0;
        @(negedge CLK_50);
        pb_seq_up = 1'b1;
        seq_m     = 6;
        chk("mid_seq_num", 32'(seq_num), 32'd6);
        chk("mid_busy", 32'(busy), 32'd1);
        @(negedge CLK_50);
        chk("mid_tag_addr", 32'(tag_addr), 32'd6);
        wait_step("mid_restart_step");
        chk("mid_rom_addr", 32'(rom_addr), 32'h30);
        @(negedge CLK_50);
        chk("mid_led", 32'(led_data), 32'h055);
        stop = 1'b1;
        @(negedge CLK_50);
        stop = 1'b0;
        chk("mid_stop_busy", 32'(busy), 32'd0);

        for (int r = 0; r < 8; r++) begin
            sn   = 16 + r;
            base = 16'h80 + r * 16'h40 + $urandom_range(0, 16'h20);
            len  = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                w  = $urandom;
                lo = w[1:0];
                if (lo == 2'b11) lo = 2'b00;
                rom_mem[base + i] = {w[15:2], (i == len - 1) ? 2'b11 : lo};
            end
            tag_mem[sn] = 32'(base);
            tag_mem[sn][31] = ($urandom_range(0, 7) != 0);
            lp = 1'($urandom_range(0, 1));
            run_playback(sn, lp, lp ? len + $urandom_range(1, 4) : 2000);
        end

        // Reset asserted while in ROM_W clears everything.
        goto_seq(5);
        loop_en = 1'b1;
        start   = 1'b1;
        @(negedge CLK_50);
        start = 1'b0;
        wait_step("rst_mid_step");
        for (int k = 0; k < 8 && (cyc % TICK_DIV) != 0; k++) @(negedge CLK_50);
        chk("rst_mid_in_rom_w", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge CLK_50);
        chk("rstm_seq_num",  32'(seq_num),    32'd0);
        chk("rstm_tag_addr", 32'(tag_addr),   32'd0);
        chk("rstm_rom_addr", 32'(rom_addr),   32'd0);
        chk("rstm_led_data", 32'(led_data),   32'd0);
        chk("rstm_busy",     32'(busy),       32'd0);
        chk("rstm_step",     32'(step_pulse), 32'd0);
        chk("rstm_done",     32'(done),       32'd0);
        chk("rstm_tag_err",  32'(tag_err),    32'd0);
        reset = 1'b0;
        seq_m = 0;
        @(negedge CLK_50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
